// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch stage and its fetch queue.
// Widths and defaults live here so the top and the queue agree on them.
package if_pkg;

  localparam int          ILEN         = 32;
  localparam int          PC_INC       = 4;
  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam int          DEF_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_FQ_DEPTH = 2;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// In-order fetch queue: entry allocated at request issue, filled in order by responses, popped at head.
// Head is a mux of flops (no input-to-output path); flush empties it in one cycle; caller never allocates when full.
module fetch_queue
  import if_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int DEPTH = DEF_FQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic                   flush_i,
  input  logic                   alloc_vld_i,
  input  logic [XLEN-1:0]        alloc_pc_i,
  input  logic                   fill_vld_i,
  input  logic [ILEN-1:0]        fill_dat_i,
  input  logic                   pop_i,
  output logic                   head_vld_o,
  output logic [ILEN-1:0]        head_dat_o,
  output logic [XLEN-1:0]        head_pc_o,
  output logic [$clog2(DEPTH):0] occ_o,
  output logic [$clog2(DEPTH):0] unfilled_o
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW:0] ptr_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t PTR_FULL = ptr_t'(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  ptr_t            head_q, head_d;
  ptr_t            fill_q, fill_d;
  ptr_t            tail_q, tail_d;
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [ILEN-1:0] dat_q [DEPTH];
  logic            do_alloc;
  logic            do_fill;
  logic            do_pop;

  assign occ_o      = tail_q - head_q;
  assign unfilled_o = tail_q - fill_q;
  assign head_vld_o = (fill_q != head_q);
  assign head_pc_o  = pc_q[head_q[PW-1:0]];
  assign head_dat_o = dat_q[head_q[PW-1:0]];

  assign do_alloc = alloc_vld_i && !flush_i && (occ_o != PTR_FULL);
  assign do_fill  = fill_vld_i && !flush_i && (unfilled_o != '0);
  assign do_pop   = pop_i && !flush_i && head_vld_o;

  always_comb begin
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = tail_q;
      fill_d = tail_q;
    end else begin
      if (do_alloc) tail_d = tail_q + PTR_ONE;
      if (do_fill)  fill_d = fill_q + PTR_ONE;
      if (do_pop)   head_d = head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      if (do_alloc) pc_q[tail_q[PW-1:0]]  <= alloc_pc_i;
      if (do_fill)  dat_q[fill_q[PW-1:0]] <= fill_dat_i;
    end
  end

  assert property (@(posedge clk) disable iff (!res_n) alloc_vld_i |-> (occ_o != PTR_FULL))
    else $error("fetch_queue: allocate while full");

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order fetches, buffers instr/PC pairs for decode; fire n -> decode n+2.
// Issue stalls when occupancy plus dropped-in-flight reaches FQ_DEPTH; redirect flushes and drops stale responses.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int              FQ_DEPTH = DEF_FQ_DEPTH
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            if_id_valid,
  input  logic            if_id_ready,
  output logic [ILEN-1:0] if_id,
  output logic [XLEN-1:0] if_id_pc
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [CW-1:0]   cnt_t;
  typedef logic [CW:0]     sum_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam sum_t LIMIT   = sum_t'(FQ_DEPTH);

  addr_t pc_q, pc_d;
  cnt_t  drop_q, drop_d;
  cnt_t  occ;
  cnt_t  unfilled;
  logic  fire;
  logic  pop;
  logic  rsp_drop;
  logic  rsp_live;
  logic  unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credits: every allocated entry and every response still owed to a flushed request.
  assign imem_req_valid = ((sum_t'(occ) + sum_t'(drop_q)) < LIMIT) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;
  assign pop            = if_id_valid && if_id_ready && !redirect_valid;
  assign rsp_drop       = imem_rsp_valid && (drop_q != '0);
  assign rsp_live       = imem_rsp_valid && (drop_q == '0) && (unfilled != '0);

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      // Whatever arrives this cycle retires one outstanding request, live or already dropped.
      drop_d = drop_q + unfilled - ((rsp_drop || rsp_live) ? CNT_ONE : cnt_t'(0));
    end else begin
      if (fire)     pc_d   = pc_q + addr_t'(PC_INC);
      if (rsp_drop) drop_d = drop_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk         (clk),
    .res_n       (res_n),
    .flush_i     (redirect_valid),
    .alloc_vld_i (fire),
    .alloc_pc_i  (pc_q),
    .fill_vld_i  (rsp_live && !redirect_valid),
    .fill_dat_i  (imem_rsp_data),
    .pop_i       (pop),
    .head_vld_o  (if_id_valid),
    .head_dat_o  (if_id),
    .head_pc_o   (if_id_pc),
    .occ_o       (occ),
    .unfilled_o  (unfilled)
  );

  assert property (@(posedge clk) disable iff (!res_n)
                   imem_rsp_valid |-> ((drop_q != '0) || (unfilled != '0)))
    else $error("if_fetch_unit: response with nothing outstanding");

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: a memory model answers every fire in order, a scoreboard of
// program-order PCs is rebuilt on reset and redirect, and a monitor checks every instruction decode accepts.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk;
  logic        res_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_id_valid;
  logic        if_id_ready;
  logic [31:0] if_id;
  logic [31:0] if_id_pc;

  if_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RST_PC),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .res_n          (res_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_valid    (if_id_valid),
    .if_id_ready    (if_id_ready),
    .if_id          (if_id),
    .if_id_pc       (if_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_err;
  int          cyc;
  int          lat;
  int          n_fire;
  int          n_acc;
  int          first_acc;
  int          wrap_cnt;
  bit          rsp_jitter;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  exp_t        exp_q     [$];
  exp_t        push_e;
  exp_t        mon_e;
  logic [31:0] model_pc;
  bit          addr_chk_pend;
  logic [31:0] addr_exp;
  bit          prev_fire_vld;
  logic [31:0] prev_fire_addr;
  int          c0;
  int          f0;
  int          a0;
  bit          ok;
  bit          r_rdr;
  logic [31:0] r_tgt;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ NOP;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    if_id_ready    = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exp_q.delete();
    model_pc      = RST_PC;
    first_acc     = -1;
    prev_fire_vld = 1'b0;
    addr_chk_pend = 1'b0;
    #1;
    check("reset_if_id_valid", 32'(if_id_valid), 32'd0);
    check("reset_if_id", if_id, 32'd0);
    check("reset_if_id_pc", if_id_pc, 32'd0);
    check("reset_req_addr", imem_req_addr, RST_PC);
    repeat (2) @(negedge clk);
  endtask

  // One clock of stimulus: memory answers, inputs driven at negedge, fire observed once settled.
  task automatic cycle(input bit rdr, input logic [31:0] tgt, input bit req_rdy, input bit dec_rdy);
    @(negedge clk);
    cyc++;
    res_n = 1'b1;
    if (pend_due.size() > 0 && pend_due[0] <= cyc && !(rsp_jitter && $urandom_range(0, 3) == 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    redirect_valid = rdr;
    redirect_pc    = tgt;
    imem_req_ready = req_rdy;
    if_id_ready    = dec_rdy;
    if (rdr) begin
      exp_q.delete();
      model_pc      = {tgt[31:2], 2'b00};
      addr_exp      = {tgt[31:2], 2'b00};
      addr_chk_pend = 1'b1;
      prev_fire_vld = 1'b0;
    end
    while (exp_q.size() < 4) begin
      push_e.pc  = model_pc;
      push_e.ins = instr_of(model_pc);
      exp_q.push_back(push_e);
      model_pc = model_pc + 32'd4;
    end
    #1;
    if (rdr) check("redirect_req_low", 32'(imem_req_valid), 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      n_fire++;
      if (addr_chk_pend) begin
        check("redirect_addr", imem_req_addr, addr_exp);
        addr_chk_pend = 1'b0;
      end
      if (prev_fire_vld && prev_fire_addr == 32'hFFFF_FFFC) begin
        wrap_cnt++;
        check("wrap_addr", imem_req_addr, 32'h0000_0000);
      end
      prev_fire_vld  = 1'b1;
      prev_fire_addr = imem_req_addr;
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (res_n && if_id_valid && if_id_ready && !redirect_valid) begin
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL scoreboard_empty: got pc 0x%08h, no instruction expected", if_id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("decode_pc", if_id_pc, mon_e.pc);
        check("decode_instr", if_id, mon_e.ins);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_id_ready = 1'b0;
    n_chk = 0; n_err = 0; cyc = 0; lat = 1; n_fire = 0; n_acc = 0; first_acc = -1; wrap_cnt = 0;
    rsp_jitter = 1'b0; model_pc = RST_PC; addr_chk_pend = 1'b0; addr_exp = '0;
    prev_fire_vld = 1'b0; prev_fire_addr = '0;

    // Streaming from reset with a 1-cycle memory.
    do_reset();
    c0 = cyc + 1;
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RST_PC);
    repeat (15) cycle(1'b0, '0, 1'b1, 1'b1);
    check("first_decode_latency", 32'(first_acc - c0), 32'd2);

    // Mid-stream reset followed by a decode stall.
    do_reset();
    f0 = n_fire;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      if (i >= 3) begin
        check("stall_head_valid", 32'(if_id_valid), 32'd1);
        check("stall_head_pc", if_id_pc, RST_PC);
        check("stall_head_instr", if_id, instr_of(RST_PC));
      end
    end
    check("stall_fire_count", 32'(n_fire - f0), 32'(DEPTH));
    check("stall_req_low", 32'(imem_req_valid), 32'd0);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    // Redirect to 0x100 with two fetches in flight.
    lat = 3;
    ok  = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      ok = (pend_addr.size() >= 2);
    end
    check("inflight_setup", 32'(pend_addr.size()), 32'd2);
    cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    repeat (15) cycle(1'b0, '0, 1'b1, 1'b1);
    check("redirect_fetch_done", 32'(addr_chk_pend), 32'd0);

    // Misaligned redirect target.
    lat = 1;
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
    check("misaligned_fetch_done", 32'(addr_chk_pend), 32'd0);

    // PC wrap at the top of the address space.
    cycle(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1);
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b1);
    check("wrap_observed", 32'(wrap_cnt > 0), 32'd1);

    // Random backpressure, jittered latency and random redirects.
    rsp_jitter = 1'b1;
    for (int i = 0; i < 500; i++) begin
      lat   = (i < 250) ? 1 : 3;
      r_rdr = ($urandom_range(0, 24) == 0);
      r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(r_rdr, r_tgt, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    // Drain with everything ready; the stream must keep moving.
    rsp_jitter = 1'b0;
    lat        = 1;
    a0         = n_acc;
    repeat (30) cycle(1'b0, '0, 1'b1, 1'b1);
    check("drain_progress", 32'((n_acc - a0) >= 10), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
